// File: rtl/sd_spi_shifter_if.sv
// Avalon-MM slave bus bundle for the SD-card SPI shifter.
// The host drives the request side and reads back the combinational readdata.
interface sd_spi_shifter_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, output chipselect, output write_n, output writedata, input readdata);
    modport slave  (input address, input chipselect, input write_n, input writedata, output readdata);
endinterface

// File: rtl/sd_spi_shifter.sv
// Byte-wide SPI mode-0 shifter for SD cards, MSB first, with a programmable clock divider.
// Card select is a plain software register and is never driven by the transfer FSM.
module sd_spi_shifter #(
    parameter logic [7:0] DIV_RESET = 8'd63
) (
    input  logic                     clk,
    input  logic                     reset_n,
    sd_spi_shifter_if.slave          bus,
    input  logic                     sd_miso,
    output logic                     sd_clk,
    output logic                     sd_mosi,
    output logic                     sd_cs_n
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    logic [1:0] state_r;
    logic [7:0] cnt_r;
    logic [2:0] bit_r;
    logic [7:0] shift_r;
    logic [7:0] rxdata_r;
    logic [7:0] divider_r;
    logic       busy_r;
    logic       rx_valid_r;
    logic       cs_r;
    logic       sd_clk_r;
    logic       sd_mosi_r;
    logic       wr_s;
    logic       unused_s;

    assign wr_s     = bus.chipselect & ~bus.write_n;
    assign unused_s = ^bus.writedata[31:8];

    assign sd_clk  = sd_clk_r;
    assign sd_mosi = sd_mosi_r;
    assign sd_cs_n = cs_r;

    // Register read mux; readdata is combinational on address.
    always_comb begin
        bus.readdata = 32'd0;
        case (bus.address)
            2'd0:    bus.readdata = {24'd0, rxdata_r};
            2'd1:    bus.readdata = {30'd0, rx_valid_r, busy_r};
            2'd2:    bus.readdata = {24'd0, divider_r};
            2'd3:    bus.readdata = {31'd0, cs_r};
            default: bus.readdata = 32'd0;
        endcase
    end

    // Control registers plus the IDLE/LOW/HIGH transfer sequencer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            bit_r      <= 3'd0;
            shift_r    <= 8'd0;
            rxdata_r   <= 8'd0;
            divider_r  <= DIV_RESET;
            busy_r     <= 1'b0;
            rx_valid_r <= 1'b0;
            cs_r       <= 1'b1;
            sd_clk_r   <= 1'b0;
            sd_mosi_r  <= 1'b1;
        end else begin
            if (wr_s && (bus.address == 2'd3)) begin
                cs_r <= bus.writedata[0];
            end else begin
                cs_r <= cs_r;
            end
            // The divider is frozen while busy so the half-period compare stays consistent.
            if (wr_s && (bus.address == 2'd2) && !busy_r) begin
                divider_r <= bus.writedata[7:0];
            end else begin
                divider_r <= divider_r;
            end

            case (state_r)
                ST_IDLE: begin
                    sd_clk_r <= 1'b0;
                    cnt_r    <= 8'd0;
                    bit_r    <= 3'd0;
                    if (wr_s && (bus.address == 2'd0)) begin
                        shift_r    <= bus.writedata[7:0];
                        sd_mosi_r  <= bus.writedata[7];
                        busy_r     <= 1'b1;
                        rx_valid_r <= 1'b0;
                        state_r    <= ST_LOW;
                    end else begin
                        sd_mosi_r <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (cnt_r == divider_r) begin
                        cnt_r    <= 8'd0;
                        sd_clk_r <= 1'b1;
                        shift_r  <= {shift_r[6:0], sd_miso};
                        state_r  <= ST_HIGH;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (cnt_r == divider_r) begin
                        cnt_r    <= 8'd0;
                        sd_clk_r <= 1'b0;
                        if (bit_r == 3'd7) begin
                            rxdata_r   <= shift_r;
                            rx_valid_r <= 1'b1;
                            busy_r     <= 1'b0;
                            sd_mosi_r  <= 1'b1;
                            bit_r      <= 3'd0;
                            state_r    <= ST_IDLE;
                        end else begin
                            // After the capture shift, bit 7 already holds the next bit to send.
                            bit_r     <= bit_r + 3'd1;
                            sd_mosi_r <= shift_r[7];
                            state_r   <= ST_LOW;
                        end
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= 8'd0;
                    bit_r     <= 3'd0;
                    busy_r    <= 1'b0;
                    sd_clk_r  <= 1'b0;
                    sd_mosi_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_shifter.sv
// Scoreboard bench for sd_spi_shifter: stimulus queues the expected byte and timing,
// a negedge monitor checks every completed transfer, a card model answers on sd_miso.
module tb_sd_spi_shifter;
    logic clk;
    logic reset_n;
    logic sd_miso;
    logic sd_clk;
    logic sd_mosi;
    logic sd_cs_n;

    sd_spi_shifter_if bus ();

    sd_spi_shifter #(.DIV_RESET(8'd63)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .sd_miso (sd_miso),
        .sd_clk  (sd_clk),
        .sd_mosi (sd_mosi),
        .sd_cs_n (sd_cs_n)
    );

    typedef struct {
        logic [7:0] tx;
        int         div;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Card model: presents its MSB at start, advances on each falling sd_clk.
    logic [7:0] card_byte;
    int         card_idx;
    always @(negedge sd_clk) begin
        if (card_idx < 7) begin
            card_idx = card_idx + 1;
            sd_miso  = card_byte[7 - card_idx];
        end
    end

    // Monitor: measures busy length, sd_clk run lengths and transmitted bits.
    logic       prev_busy = 1'b0;
    logic       prev_sdclk = 1'b0;
    int         busy_cnt, run_len, pulses, half_err, cur_div;
    logic [7:0] mosi_byte;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_busy  = 1'b0;
            prev_sdclk = 1'b0;
        end else begin
            if (dut.busy_r && !prev_busy) begin
                busy_cnt = 0; run_len = 0; pulses = 0; half_err = 0; mosi_byte = 8'd0;
                prev_sdclk = 1'b0;
                cur_div = (exp_q.size() != 0) ? exp_q[0].div : 0;
            end
            if (dut.busy_r) begin
                busy_cnt++;
                if (sd_clk == prev_sdclk) begin
                    run_len++;
                end else begin
                    if (run_len != cur_div + 1) half_err++;
                    run_len = 1;
                    if (sd_clk) begin
                        pulses++;
                        mosi_byte = {mosi_byte[6:0], sd_mosi};
                    end
                end
                prev_sdclk = sd_clk;
            end else if (prev_busy) begin
                if (run_len != cur_div + 1) half_err++;
                if (exp_q.size() == 0) begin
                    check("unexpected_transfer", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("mosi_byte", {24'd0, mosi_byte}, {24'd0, e.tx});
                    check("busy_cycles", busy_cnt, 16 * (e.div + 1));
                    check("sd_clk_pulses", pulses, 32'd8);
                    check("half_period_errors", half_err, 32'd0);
                end
            end
            prev_busy = dut.busy_r;
        end
    end

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.address = addr; bus.writedata = data; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.address = addr; bus.chipselect = 1'b1;
        #1 data = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [1:0] addr, input logic [31:0] req);
        logic [31:0] d;
        bus_read(addr, d);
        check(name, d, req);
    endtask

    task automatic start_xfer(input logic [7:0] tx, input logic [7:0] card, input int div, input bit track);
        card_byte = card;
        card_idx  = 0;
        sd_miso   = card[7];
        if (track) begin
            exp_t e;
            e.tx = tx; e.div = div;
            exp_q.push_back(e);
        end
        bus_write(2'd0, {24'd0, tx});
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("transfer_timeout", exp_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        sd_miso = 1'b1;
        card_byte = 8'hFF; card_idx = 7;
        bus.address = 2'd0; bus.writedata = 32'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        read_check("rst_status", 2'd1, 32'd0);
        read_check("rst_divider", 2'd2, 32'd63);
        read_check("rst_csctl", 2'd3, 32'd1);
        read_check("rst_rxdata", 2'd0, 32'd0);
        check("rst_sd_clk", sd_clk, 1'b0);
        check("rst_sd_mosi", sd_mosi, 1'b1);
        check("rst_sd_cs_n", sd_cs_n, 1'b1);

        // Divider 1, send A5 / receive 3C, ignored second write of FF mid-transfer
        bus_write(2'd2, 32'd1);
        read_check("div_set1", 2'd2, 32'd1);
        start_xfer(8'hA5, 8'h3C, 1, 1'b1);
        repeat (4) @(negedge clk);
        bus_write(2'd0, 32'h0000_00FF);
        wait_done();
        read_check("rx_3c", 2'd0, 32'h3C);
        read_check("status_done", 2'd1, 32'd2);

        // Divider write during busy is ignored
        start_xfer(8'h5A, 8'h81, 1, 1'b1);
        repeat (2) @(negedge clk);
        bus_write(2'd2, 32'd0);
        read_check("div_locked", 2'd2, 32'd1);
        read_check("status_busy", 2'd1, 32'd1);
        wait_done();
        read_check("rx_81", 2'd0, 32'h81);

        // Divider 0: sd_clk = clk/2, busy 16 cycles
        bus_write(2'd2, 32'd0);
        read_check("div_set0", 2'd2, 32'd0);
        start_xfer(8'hC3, 8'h96, 0, 1'b1);
        wait_done();
        read_check("rx_96", 2'd0, 32'h96);
        read_check("status_div0", 2'd1, 32'd2);

        // Card select low around a transfer
        bus_write(2'd3, 32'd0);
        #1 check("cs_low", sd_cs_n, 1'b0);
        start_xfer(8'h00, 8'hFF, 0, 1'b1);
        repeat (4) @(negedge clk);
        check("cs_low_mid", sd_cs_n, 1'b0);
        wait_done();
        read_check("rx_ff", 2'd0, 32'hFF);
        bus_write(2'd3, 32'd1);
        #1 check("cs_high_after", sd_cs_n, 1'b1);

        // Reset mid-transfer after three sd_clk pulses
        bus_write(2'd2, 32'd1);
        bus_write(2'd3, 32'd0);
        start_xfer(8'hA5, 8'h3C, 1, 1'b0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dut.busy_r && pulses >= 3) break;
        end
        check("abort_reached_3_pulses", pulses, 32'd3);
        reset_n = 1'b0;
        #1;
        check("abort_sd_clk", sd_clk, 1'b0);
        check("abort_sd_mosi", sd_mosi, 1'b1);
        check("abort_sd_cs_n", sd_cs_n, 1'b1);
        read_check("abort_rxdata", 2'd0, 32'd0);
        read_check("abort_status", 2'd1, 32'd0);
        read_check("abort_divider", 2'd2, 32'd63);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        read_check("abort_stays_idle", 2'd1, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
